// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : shared geometry and FSM state encoding for dcache_ctrl
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int BLOCK_SIZE = 2;
    localparam int LINE_SIZE  = 32;
    localparam int ADDR_SIZE  = 32;
    localparam int INDEX_BITS = 3;

    localparam int TAG_BITS   = ADDR_SIZE - INDEX_BITS - BLOCK_SIZE - 2;
    localparam int WORDS      = 1 << BLOCK_SIZE;
    localparam int BLOCK_BITS = WORDS * LINE_SIZE;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + BLOCK_SIZE;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_BITS;
    localparam int BADDR_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2
    } state_t;

    function automatic logic [BLOCK_BITS-1:0] merge_word(
        input logic [BLOCK_BITS-1:0] line,
        input logic [BLOCK_SIZE-1:0] sel,
        input logic [LINE_SIZE-1:0]  word
    );
        logic [BLOCK_BITS-1:0] merged;
        merged = line;
        merged[sel*LINE_SIZE +: LINE_SIZE] = word;
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ============================================================================
// dcache_line_store : data/tag/valid/dirty arrays, async read, sync write
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dcache_line_store
    import cache_pkg::*;
(
    input  logic                  m_clk_i,
    input  logic                  m_reset_i,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [BLOCK_BITS-1:0] rd_line,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [BLOCK_BITS-1:0] wr_line,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  wr_dirty
);

    logic [BLOCK_BITS-1:0] data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;

    // Payload arrays are deliberately not reset; only the state bits are.
    always_ff @(posedge m_clk_i) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_line;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    assign rd_line  = data_mem[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped write-back/write-allocate data cache controller
//               Optional CACHE_STATS_EN adds hit/miss counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
    import cache_pkg::*;
(
    input  logic                  m_clk_i,
    input  logic                  m_reset_i,
    input  logic                  c_read_i,
    input  logic                  c_write_i,
    input  logic [ADDR_SIZE-1:0]  c_addr_i,
    input  logic [LINE_SIZE-1:0]  c_wr_data_i,
    output logic [LINE_SIZE-1:0]  c_read_data_o,
    output logic                  c_busywait_o,
    output logic                  m_read_o,
    output logic                  m_wr_o,
    output logic [BADDR_BITS-1:0] m_addr_o,
    output logic [BLOCK_BITS-1:0] m_wr_data_o,
    input  logic [BLOCK_BITS-1:0] m_read_data_i,
    input  logic                  m_busywait_i,
    input  logic                  m_read_done_i,
    input  logic                  m_write_done_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    state_t state, state_nx;

    logic [INDEX_BITS-1:0] cpu_idx;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [BLOCK_SIZE-1:0] word_sel;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [TAG_BITS-1:0]   victim_tag;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [BLOCK_BITS-1:0] rd_line;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [BLOCK_BITS-1:0] wr_line;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_dirty;

    logic req;
    logic hit;
    logic unused_inputs;

    assign cpu_idx  = c_addr_i[INDEX_LSB +: INDEX_BITS];
    assign cpu_tag  = c_addr_i[TAG_LSB +: TAG_BITS];
    assign word_sel = c_addr_i[OFFSET_LSB +: BLOCK_SIZE];

    // Memory busy is informational only; the done pulses sequence the FSM.
    assign unused_inputs = ^{m_busywait_i, c_addr_i[1:0]};

    assign rd_idx = (state == IDLE) ? cpu_idx : req_idx;

    dcache_line_store u_store (
        .m_clk_i   (m_clk_i),
        .m_reset_i (m_reset_i),
        .rd_idx    (rd_idx),
        .rd_line   (rd_line),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_line   (wr_line),
        .wr_tag    (wr_tag),
        .wr_dirty  (wr_dirty)
    );

    assign req          = c_read_i | c_write_i;
    assign hit          = rd_valid & (rd_tag == cpu_tag);
    assign c_busywait_o = req & (~hit | (state != IDLE));

    assign c_read_data_o = (c_read_i && hit && state == IDLE)
                         ? rd_line[word_sel*LINE_SIZE +: LINE_SIZE]
                         : '0;

    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge m_clk_i) begin
        if (state == IDLE && req && !hit) begin
            req_idx    <= cpu_idx;
            req_tag    <= cpu_tag;
            victim_tag <= rd_tag;
        end
    end

    always_comb begin
        state_nx    = state;
        m_read_o    = 1'b0;
        m_wr_o      = 1'b0;
        m_addr_o    = '0;
        m_wr_data_o = '0;
        wr_en       = 1'b0;
        wr_idx      = cpu_idx;
        wr_line     = merge_word(rd_line, word_sel, c_wr_data_i);
        wr_tag      = cpu_tag;
        wr_dirty    = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        wr_en = c_write_i;
                    end else begin
                        state_nx = (rd_valid && rd_dirty) ? WB : ALLOC;
                    end
                end
            end
            WB: begin
                m_addr_o    = {victim_tag, req_idx};
                m_wr_data_o = rd_line;
                m_wr_o      = ~m_write_done_i;
                if (m_write_done_i) begin
                    state_nx = ALLOC;
                end
            end
            ALLOC: begin
                m_addr_o = {req_tag, req_idx};
                m_read_o = ~m_read_done_i;
                if (m_read_done_i) begin
                    wr_en    = 1'b1;
                    wr_idx   = req_idx;
                    wr_line  = m_read_data_i;
                    wr_tag   = req_tag;
                    wr_dirty = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        refill_ret;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // The post-refill hit is the tail of a miss already counted, so skip it.
    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            refill_ret <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            refill_ret <= (state == ALLOC) && m_read_done_i;
            if (state == IDLE && req && !refill_ret) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`endif

endmodule

`default_nettype wire
